// File: rtl/axis_fifo_pkg.sv
// Shared constants for the AXI-Stream FIFO: sideband width, entry field offsets
// and a constant-evaluable ceil(log2) helper.
package axis_fifo_pkg;

    // Entry layout is {tuser, tlast, tdata}; sideband offsets are relative to DATA_WIDTH.
    localparam int unsigned SB_WIDTH  = 2;
    localparam int unsigned TDATA_OFS = 0;
    localparam int unsigned TLAST_REL = 0;
    localparam int unsigned TUSER_REL = 1;

    function automatic int unsigned f_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with registered, enabled read.
// No reset on storage or read register so it maps onto block RAM.
module axis_fifo_ram
    import axis_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned ADDR_W = f_clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read data holds while i_rd_en is low; the top relies on this as a skid stage.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through AXI-Stream FIFO: block RAM, RAM read stage, output register.
// Define AXIS_SYNC_FIFO_LEVEL_EN to build the level counter and almost_full.
module axis_sync_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned AF_THRESH  = DEPTH - 16
) (
    input  logic                    aclk,
    input  logic                    rst,

    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,

    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,

    output logic [$clog2(DEPTH):0]  level,
    output logic                    almost_full
);

    localparam int unsigned AW = f_clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + SB_WIDTH;

    if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_data_width
        $error("axis_sync_fifo: DATA_WIDTH must be 1..64");
    end
    if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_sync_fifo: DEPTH must be a power of two in 16..4096");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af_thresh
        $error("axis_sync_fifo: AF_THRESH must not exceed DEPTH");
    end

    logic          w_wr_fire;
    logic          w_rd_fire;
    logic          w_move;
    logic          w_ram_rd;
    logic          w_ram_nempty;
    logic          w_full_nxt;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_rd_entry;

    logic                  r_s_ready;
    logic                  r_ram_valid;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic                  r_out_user;

    assign w_wr_entry = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    assign w_wr_fire  = s_axis_tvalid && r_s_ready;
    assign w_rd_fire  = r_out_valid && m_axis_tready;

    // RAM output advances into the output register whenever that slot frees up;
    // a new RAM read is only issued when the RAM output is free or moving this edge.
    assign w_move   = r_ram_valid && (!r_out_valid || w_rd_fire);
    assign w_ram_rd = w_ram_nempty && (!r_ram_valid || w_move);

`ifdef AXIS_SYNC_FIFO_LEVEL_EN
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_almost_full;
    logic [LW-1:0] w_level_nxt;
    logic [LW-1:0] w_ram_cnt;

    // Words still in RAM = total held minus the two pipeline stages.
    assign w_ram_cnt    = r_level - LW'(r_ram_valid) - LW'(r_out_valid);
    assign w_ram_nempty = (w_ram_cnt != '0);
    assign w_level_nxt  = r_level + LW'(w_wr_fire) - LW'(w_rd_fire);
    assign w_full_nxt   = (w_level_nxt == LW'(DEPTH));
    assign w_wr_addr    = r_wptr;
    assign w_rd_addr    = r_rptr;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_level       <= w_level_nxt;
            r_almost_full <= (w_level_nxt >= LW'(AF_THRESH));
            if (w_wr_fire) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_ram_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    assign level       = r_level;
    assign almost_full = r_almost_full;
`else
    // Pointers carry a wrap bit; r_cptr counts words consumed at the output so
    // that fullness covers the RAM plus both pipeline stages.
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] r_cptr;
    logic [AW:0] w_wptr_nxt;
    logic [AW:0] w_cptr_nxt;

    assign w_ram_nempty = (r_wptr != r_rptr);
    assign w_wptr_nxt   = r_wptr + LW'(w_wr_fire);
    assign w_cptr_nxt   = r_cptr + LW'(w_rd_fire);
    assign w_full_nxt   = (w_wptr_nxt[AW] != w_cptr_nxt[AW]) &&
                          (w_wptr_nxt[AW-1:0] == w_cptr_nxt[AW-1:0]);
    assign w_wr_addr    = r_wptr[AW-1:0];
    assign w_rd_addr    = r_rptr[AW-1:0];

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_cptr <= w_cptr_nxt;
            if (w_ram_rd) begin
                r_rptr <= r_rptr + LW'(1);
            end
        end
    end

    assign level       = '0;
    assign almost_full = 1'b0;
`endif

    axis_fifo_ram #(
        .WIDTH  (EW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .i_clk     (aclk),
        .i_wr_en   (w_wr_fire),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_entry)
    );

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_s_ready   <= 1'b0;
            r_ram_valid <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= 1'b0;
        end else begin
            r_s_ready <= !w_full_nxt;

            if (w_ram_rd) begin
                r_ram_valid <= 1'b1;
            end else if (w_move) begin
                r_ram_valid <= 1'b0;
            end

            if (w_move) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rd_entry[TDATA_OFS +: DATA_WIDTH];
                r_out_last  <= w_rd_entry[DATA_WIDTH + TLAST_REL];
                r_out_user  <= w_rd_entry[DATA_WIDTH + TUSER_REL];
            end else if (w_rd_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = r_out_user;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo (DATA_WIDTH=10, DEPTH=16, AF_THRESH=12).
// Level/almost_full expectations follow AXIS_SYNC_FIFO_LEVEL_EN.
module tb_axis_sync_fifo;

    logic       aclk = 1'b0;
    logic       rst  = 1'b0;
    logic [9:0] s_axis_tdata  = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast  = 1'b0;
    logic       s_axis_tuser  = 1'b0;
    logic [9:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic [4:0] level;
    logic       almost_full;
    logic [31:0] obs;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    assign obs = {20'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata};

    axis_sync_fifo #(
        .DATA_WIDTH (10),
        .DEPTH      (16),
        .AF_THRESH  (12)
    ) dut (
        .aclk          (aclk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .level         (level),
        .almost_full   (almost_full)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ent(input logic u, input logic l, input logic [9:0] d);
        return {20'd0, u, l, d};
    endfunction

    function automatic logic [31:0] lvl(input int n);
`ifdef AXIS_SYNC_FIFO_LEVEL_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    function automatic logic [31:0] af(input int n);
`ifdef AXIS_SYNC_FIFO_LEVEL_EN
        return (n >= 12) ? 32'd1 : 32'd0;
`else
        return 32'(n * 0);
`endif
    endfunction

    function automatic logic [31:0] fw(input int i);
        return ent(i == 0, (i % 2) == 1, 10'(i + 32));
    endfunction

    function automatic logic [31:0] sw(input int i);
        return ent((i % 10) == 0, (i % 10) == 9, 10'(i * 7 + 3));
    endfunction

    function automatic logic [31:0] bw(input int i);
        return ent(i == 0, i == 639, 10'(i) ^ 10'h2A5);
    endfunction

    function automatic logic [31:0] ww(input int i);
        return ent((i % 7) == 0, (i % 7) == 6, 10'(i * 13 + 5));
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] e);
        s_axis_tvalid = v;
        {s_axis_tuser, s_axis_tlast, s_axis_tdata} = e[11:0];
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] e);
        int w;
        w = 0;
        while (!m_axis_tvalid && w < 8) begin
            tick();
            w++;
        end
        chk({tag, "_vld"}, 32'(m_axis_tvalid), 32'd1);
        chk(tag, obs, e);
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
    endtask

    initial begin
        int wr;
        int rd;
        int cyc;
        int base;
        int n;

        // Reset values
        #2 rst = 1'b1;
        #30;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_tdata", obs, 32'd0);
        @(posedge aclk);
        #1 rst = 1'b0;
        tick();
        chk("rel_tready", 32'(s_axis_tready), 32'd1);

        // Single word: visible two edges after the write edge
        drive(1'b1, ent(1'b1, 1'b0, 10'h155));
        tick();
        drive(1'b0, 32'd0);
        chk("one_lat1", 32'(m_axis_tvalid), 32'd0);
        chk("one_lvl", 32'(level), lvl(1));
        tick();
        chk("one_lat2", 32'(m_axis_tvalid), 32'd0);
        tick();
        chk("one_vld", 32'(m_axis_tvalid), 32'd1);
        chk("one_data", obs, ent(1'b1, 1'b0, 10'h155));
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        chk("one_empty", 32'(m_axis_tvalid), 32'd0);
        chk("one_lvl0", 32'(level), lvl(0));

        // Fill to full with the sink stalled
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, fw(i));
            tick();
            chk("fill_rdy", 32'(s_axis_tready), (i < 15) ? 32'd1 : 32'd0);
            chk("fill_lvl", 32'(level), lvl(i + 1));
            chk("fill_af", 32'(almost_full), af(i + 1));
        end
        drive(1'b1, ent(1'b0, 1'b0, 10'h3FF));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("over_rdy", 32'(s_axis_tready), 32'd0);
            chk("over_lvl", 32'(level), lvl(16));
        end
        drive(1'b0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            pop_expect("drain", fw(i));
            if (i == 0) begin
                chk("full_rdy_rise", 32'(s_axis_tready), 32'd1);
            end
        end
        chk("drain_empty", 32'(m_axis_tvalid), 32'd0);
        chk("drain_lvl", 32'(level), lvl(0));

        // Streaming: 1000 words, one per cycle
        m_axis_tready = 1'b1;
        for (int c = 1; c <= 1002; c++) begin
            if (c <= 1000) begin
                drive(1'b1, sw(c - 1));
            end else begin
                drive(1'b0, 32'd0);
            end
            tick();
            if (c >= 3) begin
                chk("stream_vld", 32'(m_axis_tvalid), 32'd1);
                chk("stream", obs, sw(c - 3));
            end
            if (c >= 3 && c <= 1000) begin
                chk("stream_lvl", 32'(level), lvl(3));
            end
        end
        tick();
        m_axis_tready = 1'b0;
        chk("stream_end", 32'(m_axis_tvalid), 32'd0);
        chk("stream_lvl0", 32'(level), lvl(0));

        // Backpressure: 640-word line with random sink stalls
        wr = 0;
        rd = 0;
        cyc = 0;
        while (rd < 640 && cyc < 20000) begin
            if (m_axis_tvalid) begin
                chk("bp_data", obs, bw(rd));
            end
            chk("bp_lvl", 32'(level), lvl(wr - rd));
            m_axis_tready = 1'($urandom_range(0, 1));
            if (m_axis_tvalid && m_axis_tready) begin
                rd++;
            end
            if (wr < 640) begin
                drive(1'b1, bw(wr));
                if (s_axis_tready) begin
                    wr++;
                end
            end else begin
                drive(1'b0, 32'd0);
            end
            tick();
            cyc++;
        end
        drive(1'b0, 32'd0);
        m_axis_tready = 1'b0;
        chk("bp_count", 32'(rd), 32'd640);
        chk("bp_empty", 32'(m_axis_tvalid), 32'd0);
        chk("bp_lvl0", 32'(level), lvl(0));

        // Wrap-around: 50 words in bursts of 7
        base = 0;
        while (base < 50) begin
            n = (50 - base < 7) ? (50 - base) : 7;
            for (int k = 0; k < n; k++) begin
                drive(1'b1, ww(base + k));
                tick();
            end
            drive(1'b0, 32'd0);
            chk("wrap_lvl", 32'(level), lvl(n));
            for (int k = 0; k < n; k++) begin
                pop_expect("wrap", ww(base + k));
            end
            base += n;
        end
        chk("wrap_empty", 32'(m_axis_tvalid), 32'd0);
        chk("wrap_lvl0", 32'(level), lvl(0));

        // Reset mid-stream with 9 words held
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ww(i + 100));
            tick();
        end
        drive(1'b0, 32'd0);
        chk("mid_lvl9", 32'(level), lvl(9));
        tick();
        tick();
        chk("mid_vld", 32'(m_axis_tvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(m_axis_tvalid), 32'd0);
        chk("mid_rst_lvl", 32'(level), 32'd0);
        chk("mid_rst_rdy", 32'(s_axis_tready), 32'd0);
        chk("mid_rst_data", obs, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rel_rdy", 32'(s_axis_tready), 32'd1);
        chk("mid_rel_vld", 32'(m_axis_tvalid), 32'd0);
        drive(1'b1, ent(1'b1, 1'b1, 10'h0AB));
        tick();
        drive(1'b0, 32'd0);
        pop_expect("mid_first", ent(1'b1, 1'b1, 10'h0AB));
        tick();
        tick();
        chk("mid_after", 32'(m_axis_tvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
